// File: rtl/ws2812_serializer.sv
// ---------------------------------------------------------------------------
// ws2812_serializer
//   Turns a valid/ready stream of pixels into the single-wire NRZ-PWM
//   waveform used by WS2812-style LEDs. Each bit is TBIT cycles long. It is
//   high for T1H cycles for a '1' and for T0H cycles for a '0', then low for
//   the rest of the period. Bits go out MSB first. A frame ends with a low
//   latch period of TLATCH cycles, after which frame_done pulses.
//
// Ports
//   clk         in   PLL divided clock, sole clock
//   rst         in   synchronous active-high reset
//   pix_data    in   pixel word, bit PIX_W-1 transmitted first
//   pix_last    in   marks pix_data as the final pixel of the frame
//   pix_valid   in   upstream offers a pixel
//   pix_ready   out  one-entry holding buffer is empty
//   dout        out  registered LED data line
//   busy        out  serializer active or holding buffer occupied
//   frame_done  out  one-cycle pulse at the end of the latch period
//   underrun    out  one-cycle pulse when a pixel ends with nothing queued
//                    and no last flag; the frame is truncated into a latch
// ---------------------------------------------------------------------------
module ws2812_serializer #(
    parameter int T0H    = 60,
    parameter int T1H    = 121,
    parameter int TBIT   = 189,
    parameter int TLATCH = 42336,
    parameter int PIX_W  = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_last,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic             dout,
    output logic             busy,
    output logic             frame_done,
    output logic             underrun
);

    localparam int BW = (PIX_W > 1) ? $clog2(PIX_W) : 1;

    // Terminal counts are compared against cyc, which restarts every bit.
    localparam logic [15:0]   T0H_END    = 16'(T0H - 1);
    localparam logic [15:0]   T1H_END    = 16'(T1H - 1);
    localparam logic [15:0]   TBIT_END   = 16'(TBIT - 1);
    localparam logic [15:0]   TLATCH_END = 16'(TLATCH - 1);
    localparam logic [15:0]   CYC_ONE    = 16'd1;
    localparam logic [BW-1:0] BIT_TOP    = BW'(PIX_W - 1);
    localparam logic [BW-1:0] BIT_ONE    = BW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [15:0]        cyc_r;
    logic [15:0]        cyc_nx_s;
    logic [BW-1:0]      bitcnt_r;
    logic [BW-1:0]      bitcnt_nx_s;
    logic [PIX_W-1:0]   shift_r;
    logic [PIX_W-1:0]   shift_nx_s;
    logic               shift_last_r;
    logic               shift_last_nx_s;

    logic               buf_full_r;
    logic               buf_full_nx_s;
    logic [PIX_W-1:0]   buf_data_r;
    logic               buf_last_r;

    logic               dout_r;
    logic               busy_r;
    logic               frame_done_r;
    logic               underrun_r;

    logic               accept_s;
    logic               load_s;
    logic               frame_done_nx_s;
    logic               underrun_nx_s;
    logic [15:0]        hi_end_s;

    // Ready depends only on the buffer flag so upstream never sees a
    // combinational path from its own valid.
    assign pix_ready  = ~buf_full_r;
    assign accept_s   = pix_valid & ~buf_full_r;

    assign dout       = dout_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign underrun   = underrun_r;

    // Next-state, counter and shifter logic of the bit-timing FSM.
    always_comb begin
        state_nx_s      = state_r;
        cyc_nx_s        = cyc_r;
        bitcnt_nx_s     = bitcnt_r;
        shift_nx_s      = shift_r;
        shift_last_nx_s = shift_last_r;
        load_s          = 1'b0;
        frame_done_nx_s = 1'b0;
        underrun_nx_s   = 1'b0;
        hi_end_s        = shift_r[PIX_W-1] ? T1H_END : T0H_END;

        case (state_r)
            ST_IDLE: begin
                if (buf_full_r) begin
                    load_s          = 1'b1;
                    shift_nx_s      = buf_data_r;
                    shift_last_nx_s = buf_last_r;
                    bitcnt_nx_s     = BIT_TOP;
                    cyc_nx_s        = 16'd0;
                    state_nx_s      = ST_HIGH;
                end else begin
                    state_nx_s      = ST_IDLE;
                end
            end

            // cyc keeps counting from HIGH into LOW so the whole bit period
            // is measured by one count.
            ST_HIGH: begin
                cyc_nx_s = cyc_r + CYC_ONE;
                if (cyc_r == hi_end_s) begin
                    state_nx_s = ST_LOW;
                end else begin
                    state_nx_s = ST_HIGH;
                end
            end

            ST_LOW: begin
                if (cyc_r == TBIT_END) begin
                    cyc_nx_s = 16'd0;
                    if (bitcnt_r != '0) begin
                        shift_nx_s  = shift_r << 1;
                        bitcnt_nx_s = bitcnt_r - BIT_ONE;
                        state_nx_s  = ST_HIGH;
                    end else if (shift_last_r) begin
                        state_nx_s  = ST_LATCH;
                    end else if (buf_full_r) begin
                        // Chain straight into the queued pixel with no gap.
                        load_s          = 1'b1;
                        shift_nx_s      = buf_data_r;
                        shift_last_nx_s = buf_last_r;
                        bitcnt_nx_s     = BIT_TOP;
                        state_nx_s      = ST_HIGH;
                    end else begin
                        underrun_nx_s   = 1'b1;
                        state_nx_s      = ST_LATCH;
                    end
                end else begin
                    cyc_nx_s   = cyc_r + CYC_ONE;
                    state_nx_s = ST_LOW;
                end
            end

            // The buffer may fill here but is only consumed from IDLE.
            ST_LATCH: begin
                if (cyc_r == TLATCH_END) begin
                    frame_done_nx_s = 1'b1;
                    cyc_nx_s        = 16'd0;
                    state_nx_s      = ST_IDLE;
                end else begin
                    cyc_nx_s        = cyc_r + CYC_ONE;
                    state_nx_s      = ST_LATCH;
                end
            end

            default: begin
                cyc_nx_s   = 16'd0;
                state_nx_s = ST_IDLE;
            end
        endcase

        // An accept wins over a load on the same edge, so the buffer stays
        // full in that case.
        if (accept_s) begin
            buf_full_nx_s = 1'b1;
        end else if (load_s) begin
            buf_full_nx_s = 1'b0;
        end else begin
            buf_full_nx_s = buf_full_r;
        end
    end

    // State, datapath, holding buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cyc_r        <= 16'd0;
            bitcnt_r     <= '0;
            shift_r      <= '0;
            shift_last_r <= 1'b0;
            buf_full_r   <= 1'b0;
            buf_data_r   <= '0;
            buf_last_r   <= 1'b0;
            dout_r       <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            underrun_r   <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            cyc_r        <= cyc_nx_s;
            bitcnt_r     <= bitcnt_nx_s;
            shift_r      <= shift_nx_s;
            shift_last_r <= shift_last_nx_s;
            buf_full_r   <= buf_full_nx_s;
            if (accept_s) begin
                buf_data_r <= pix_data;
                buf_last_r <= pix_last;
            end
            // dout follows the registered state one cycle later, so the first
            // high cycle lands two edges after the handshake.
            dout_r       <= (state_r == ST_HIGH);
            busy_r       <= (state_nx_s != ST_IDLE) | buf_full_nx_s;
            frame_done_r <= frame_done_nx_s;
            underrun_r   <= underrun_nx_s;
        end
    end

endmodule
